fft16_ctrl: RTL and testbench

FFT16_CTRL -- requirements
Module: fft16_ctrl

---
 rtl/fft16_pkg.sv | 33 +++
 rtl/fft16_agu.sv | 27 ++
 rtl/fft16_ctrl.sv | 174 +++++++++++++++++
 tb/tb_fft16_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft16_pkg.sv
// Shared definitions for the 16-point in-place radix-2 FFT controller:
// state encoding, write-source select codes and the write-back record.
package fft16_pkg;

   localparam int N_POINTS  = 16;
   localparam int N_STAGES  = 4;
   localparam int N_BFLY    = N_POINTS / 2;
   localparam int ADDR_BITS = 4;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      COMPUTE,
      DRAIN,
      UNLOAD
   } state_t;

   localparam logic [1:0] SEL_INPUT = 2'b00;
   localparam logic [1:0] SEL_BFLY  = 2'b01;
   localparam logic [1:0] SEL_IDLE  = 2'b11;

   // One butterfly in flight: its write-back addresses travel with it.
   typedef struct packed {
      logic                 valid;
      logic [ADDR_BITS-1:0] a;
      logic [ADDR_BITS-1:0] b;
   } wb_t;

   function automatic logic [ADDR_BITS-1:0] bitrev4(input logic [ADDR_BITS-1:0] v);
      return {v[0], v[1], v[2], v[3]};
   endfunction

endpackage

// File: rtl/fft16_agu.sv
// Butterfly address generator: maps (stage, butterfly index) to the two
// in-place operand addresses and the twiddle ROM index. Purely combinational.
module fft16_agu
   import fft16_pkg::*;
(
   input  logic [1:0]           stage_i,
   input  logic [2:0]           k_i,
   output logic [ADDR_BITS-1:0] a_o,
   output logic [ADDR_BITS-1:0] b_o,
   output logic [2:0]           tw_o
);

   logic [ADDR_BITS-1:0] k_ext;
   logic [ADDR_BITS-1:0] half;
   logic [ADDR_BITS-1:0] pos;

   always_comb begin
      k_ext = {1'b0, k_i};
      half  = 4'd1 << stage_i;
      pos   = k_ext & (half - 4'd1);
      // Group base is (k / half) * 2 * half; the product never exceeds 14.
      a_o   = (((k_ext >> stage_i) * half) << 1) + pos;
      b_o   = a_o + half;
      tw_o  = 3'(pos << (2'd3 - stage_i));
   end

endmodule

// File: rtl/fft16_ctrl.sv
// Sequencer for a 16-point in-place FFT: bit-reversed load, four stages of
// eight butterflies with a delayed write-back, then a handshaked unload.
module fft16_ctrl
   import fft16_pkg::*;
#(
   parameter int BFLY_LAT = 2,
   parameter int ADDR_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] rd_addr_a,
   output logic [ADDR_W-1:0] rd_addr_b,
   output logic [ADDR_W-1:0] wr_addr_a,
   output logic [ADDR_W-1:0] wr_addr_b,
   output logic              wr_en_a,
   output logic              wr_en_b,
   output logic [1:0]        wr_sel,
   output logic [2:0]        tw_idx,
   output logic              bf_en,
   output logic [1:0]        stage,
   output logic              busy,
   output logic              done
);

   state_t         state_q, state_d;
   logic [3:0]     n_q, n_d;
   logic [2:0]     k_q, k_d;
   logic [2:0]     drain_q, drain_d;
   logic [3:0]     m_q, m_d;
   logic [1:0]     stage_q, stage_d;
   logic           ov_q, ov_d;
   logic           done_q, done_d;
   wb_t            dl_q [BFLY_LAT];
   wb_t            dl_d [BFLY_LAT];

   logic [ADDR_BITS-1:0] agu_a, agu_b;
   logic [2:0]           agu_tw;
   logic                 in_hs, out_hs;

   fft16_agu u_agu (
      .stage_i (stage_q),
      .k_i     (k_q),
      .a_o     (agu_a),
      .b_o     (agu_b),
      .tw_o    (agu_tw)
   );

   assign in_hs  = (state_q == LOAD) && in_valid;
   assign out_hs = (state_q == UNLOAD) && ov_q && out_ready;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         n_q     <= '0;
         k_q     <= '0;
         drain_q <= '0;
         m_q     <= '0;
         stage_q <= '0;
         ov_q    <= 1'b0;
         done_q  <= 1'b0;
         // NOTE: the delay line is reset entry by entry; a stale valid bit
         // would otherwise retire a write-back after an aborted transform.
         for (int i = 0; i < BFLY_LAT; i++) dl_q[i] <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         k_q     <= k_d;
         drain_q <= drain_d;
         m_q     <= m_d;
         stage_q <= stage_d;
         ov_q    <= ov_d;
         done_q  <= done_d;
         dl_q    <= dl_d;
      end
   end

   // NOTE: every variable gets a default at the top of each combinational
   // process so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      k_d     = k_q;
      drain_d = drain_q;
      m_d     = m_q;
      stage_d = stage_q;
      ov_d    = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: if (start) state_d = LOAD;
         LOAD: begin
            if (in_valid) begin
               n_d = n_q + 4'd1;
               if (n_q == 4'(N_POINTS - 1)) state_d = COMPUTE;
            end
         end
         COMPUTE: begin
            k_d = k_q + 3'd1;
            if (k_q == 3'(N_BFLY - 1)) state_d = DRAIN;
         end
         DRAIN: begin
            drain_d = drain_q + 3'd1;
            if (drain_q == 3'(BFLY_LAT - 1)) begin
               drain_d = '0;
               if (stage_q == 2'(N_STAGES - 1)) begin
                  state_d = UNLOAD;
                  stage_d = '0;
               end else begin
                  state_d = COMPUTE;
                  stage_d = stage_q + 2'd1;
               end
            end
         end
         UNLOAD: begin
            // Valid rises one cycle after the read address is presented.
            ov_d = 1'b1;
            if (out_hs) begin
               ov_d = 1'b0;
               m_d  = m_q + 4'd1;
               if (m_q == 4'(N_POINTS - 1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      dl_d[0] = '{valid: (state_q == COMPUTE), a: agu_a, b: agu_b};
      for (int i = 1; i < BFLY_LAT; i++) dl_d[i] = dl_q[i-1];
   end

   always_comb begin
      busy      = (state_q != IDLE);
      in_ready  = (state_q == LOAD);
      bf_en     = (state_q == COMPUTE);
      out_valid = ov_q;
      done      = done_q;
      stage     = stage_q;
      rd_addr_a = '0;
      rd_addr_b = '0;
      tw_idx    = '0;
      wr_en_a   = 1'b0;
      wr_en_b   = 1'b0;
      wr_sel    = SEL_IDLE;
      wr_addr_a = '0;
      wr_addr_b = '0;
      if (state_q == COMPUTE) begin
         rd_addr_a = ADDR_W'(agu_a);
         rd_addr_b = ADDR_W'(agu_b);
         tw_idx    = agu_tw;
      end else if (state_q == UNLOAD) begin
         rd_addr_a = ADDR_W'(m_q);
      end
      if (in_hs) begin
         wr_en_a   = 1'b1;
         wr_sel    = SEL_INPUT;
         wr_addr_a = ADDR_W'(bitrev4(n_q));
      end else if (dl_q[BFLY_LAT-1].valid) begin
         wr_en_a   = 1'b1;
         wr_en_b   = 1'b1;
         wr_sel    = SEL_BFLY;
         wr_addr_a = ADDR_W'(dl_q[BFLY_LAT-1].a);
         wr_addr_b = ADDR_W'(dl_q[BFLY_LAT-1].b);
      end
   end

endmodule

// File: tb/tb_fft16_ctrl.sv
// Directed bench for fft16_ctrl with a three-cycle butterfly, a sample memory
// and a fixed-point complex butterfly so the impulse response can be checked.
module tb_fft16_ctrl;
   import fft16_pkg::*;

   localparam int L = 3;

   logic       clk = 1'b0;
   logic       rst, start, in_valid, out_ready;
   logic       in_ready, out_valid, wr_en_a, wr_en_b, bf_en, busy, done;
   logic [3:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
   logic [1:0] wr_sel, stage;
   logic [2:0] tw_idx;

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;
   int in_re = 0;
   int mem_re [16];
   int mem_im [16];
   int rd_re, rd_im;
   int bf_half, bf_tw, bf_tr, bf_ti;
   int load_order [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
   int cos_t [8] = '{256, 237, 181, 98, 0, -98, -181, -237};
   int sin_t [8] = '{0, 98, 181, 237, 256, 237, 181, 98};

   always #5 clk = ~clk;

   fft16_ctrl #(.BFLY_LAT(L), .ADDR_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .wr_addr_a (wr_addr_a),
      .wr_addr_b (wr_addr_b),
      .wr_en_a   (wr_en_a),
      .wr_en_b   (wr_en_b),
      .wr_sel    (wr_sel),
      .tw_idx    (tw_idx),
      .bf_en     (bf_en),
      .stage     (stage),
      .busy      (busy),
      .done      (done)
   );

   // Butterfly on the pair being written back; the twiddle is rebuilt from the
   // pair spacing so the datapath does not depend on the controller's tw_idx.
   always_comb begin
      bf_half = 1;
      bf_tw   = 0;
      if (wr_addr_b > wr_addr_a) begin
         bf_half = int'(wr_addr_b) - int'(wr_addr_a);
         bf_tw   = ((int'(wr_addr_a) % bf_half) * (8 / bf_half)) & 7;
      end
      bf_tr = (mem_re[wr_addr_b] * cos_t[bf_tw] + mem_im[wr_addr_b] * sin_t[bf_tw]) >>> 8;
      bf_ti = (mem_im[wr_addr_b] * cos_t[bf_tw] - mem_re[wr_addr_b] * sin_t[bf_tw]) >>> 8;
   end

   always @(posedge clk) begin
      rd_re <= mem_re[rd_addr_a];
      rd_im <= mem_im[rd_addr_a];
      if (done) done_cnt <= done_cnt + 1;
      if (wr_en_a && wr_sel == SEL_INPUT) begin
         mem_re[wr_addr_a] <= in_re;
         mem_im[wr_addr_a] <= 0;
      end else if (wr_en_a && wr_en_b && wr_sel == SEL_BFLY) begin
         mem_re[wr_addr_a] <= mem_re[wr_addr_a] + bf_tr;
         mem_im[wr_addr_a] <= mem_im[wr_addr_a] + bf_ti;
         mem_re[wr_addr_b] <= mem_re[wr_addr_a] - bf_tr;
         mem_im[wr_addr_b] <= mem_im[wr_addr_a] - bf_ti;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) else begin
         bad = bad + 1;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Operand a is k with a zero bit inserted at position s.
   function automatic int ref_a(input int s, input int k);
      return ((k >> s) << (s + 1)) | (k & ((1 << s) - 1));
   endfunction

   function automatic int ref_tw(input int s, input int k);
      return (k & ((1 << s) - 1)) << (3 - s);
   endfunction

   task automatic do_load();
      for (int n = 0; n < 16; n++) begin
         in_valid = 1'b1;
         in_re    = (n == 0) ? 1 : 0;
         #1;
         check("load_in_ready", in_ready, 1);
         check("load_wr_en_a", wr_en_a, 1);
         check("load_wr_en_b", wr_en_b, 0);
         check("load_wr_sel", wr_sel, 0);
         check("load_addr", wr_addr_a, load_order[n]);
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic do_compute(input int n_cyc);
      int s, j;
      for (int c = 0; c < n_cyc; c++) begin
         s = c / 11;
         j = c % 11;
         #1;
         check("cmp_busy", busy, 1);
         check("cmp_bf_en", bf_en, (j < 8));
         check("cmp_stage", stage, s);
         if (j < 8) begin
            check("cmp_rd_a", rd_addr_a, ref_a(s, j));
            check("cmp_rd_b", rd_addr_b, ref_a(s, j) + (1 << s));
            check("cmp_tw", tw_idx, ref_tw(s, j));
         end
         if (j >= L) begin
            check("wb_en_a", wr_en_a, 1);
            check("wb_en_b", wr_en_b, 1);
            check("wb_sel", wr_sel, 1);
            check("wb_addr_a", wr_addr_a, ref_a(s, j - L));
            check("wb_addr_b", wr_addr_b, ref_a(s, j - L) + (1 << s));
         end else begin
            check("nowb_en_a", wr_en_a, 0);
            check("nowb_en_b", wr_en_b, 0);
            check("nowb_sel", wr_sel, 3);
         end
         // Twiddle index is pos << (3 - stage): stage 1, pos 1 -> 4.
         if (s == 1 && j == 5) begin
            check("s1k5_a", rd_addr_a, 9);
            check("s1k5_b", rd_addr_b, 11);
            check("s1k5_tw", tw_idx, 4);
         end
         if (s == 3 && j == 7) begin
            check("s3k7_a", rd_addr_a, 7);
            check("s3k7_b", rd_addr_b, 15);
            check("s3k7_tw", tw_idx, 7);
         end
         if (s == 0 && j == 3) begin
            check("s0k3_a", rd_addr_a, 6);
            check("s0k3_b", rd_addr_b, 7);
            check("s0k3_tw", tw_idx, 0);
         end
         tick();
      end
   endtask

   task automatic do_unload();
      for (int m = 0; m < 16; m++) begin
         out_ready = 1'b1;
         #1;
         check("unl_addr_phase_valid", out_valid, 0);
         check("unl_addr", rd_addr_a, m);
         check("unl_busy", busy, 1);
         check("unl_no_wr", wr_en_a, 0);
         tick();
         if (m == 6) begin
            out_ready = 1'b0;
            for (int h = 0; h < 5; h++) begin
               #1;
               check("bp_valid", out_valid, 1);
               check("bp_addr", rd_addr_a, 6);
               tick();
            end
            out_ready = 1'b1;
         end
         #1;
         check("unl_valid", out_valid, 1);
         check("unl_addr_hold", rd_addr_a, m);
         check("unl_re", rd_re, 1);
         check("unl_im", rd_im, 0);
         check("unl_done_early", done, 0);
         tick();
      end
      #1;
      check("done_pulse", done, 1);
      check("done_busy", busy, 0);
      check("done_out_valid", out_valid, 0);
      tick();
      #1;
      check("done_low", done, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_bf_en", bf_en, 0);
      check("rst_wr_en_a", wr_en_a, 0);
      check("rst_wr_en_b", wr_en_b, 0);
      check("rst_wr_sel", wr_sel, 3);
      check("rst_rd_a", rd_addr_a, 0);
      check("rst_rd_b", rd_addr_b, 0);
      check("rst_wr_a", wr_addr_a, 0);
      check("rst_wr_b", wr_addr_b, 0);
      check("rst_tw", tw_idx, 0);
      check("rst_stage", stage, 0);
      rst = 1'b0;
      tick();

      // IDLE ignores in_valid; start is taken on the next edge.
      in_valid = 1'b1;
      #1;
      check("idle_in_valid_wr", wr_en_a, 0);
      check("idle_in_ready", in_ready, 0);
      tick();
      in_valid = 1'b0;
      start    = 1'b1;
      #1;
      check("idle_busy", busy, 0);
      tick();
      start = 1'b0;
      #1;
      check("load_busy", busy, 1);
      check("load_ready", in_ready, 1);
      check("load_stall_wr", wr_en_a, 0);
      check("load_stall_sel", wr_sel, 3);
      tick();

      // Run 1: start and in_valid held during compute must be ignored.
      do_load();
      start    = 1'b1;
      in_valid = 1'b1;
      do_compute(44);
      start    = 1'b0;
      in_valid = 1'b0;
      do_unload();
      check("done_count_1", done_cnt, 1);

      // Run 2: abort at stage 2, k=4 while a write-back is pending.
      start = 1'b1;
      tick();
      start = 1'b0;
      do_load();
      do_compute(26);
      #1;
      check("abort_bf_en", bf_en, 1);
      check("abort_stage", stage, 2);
      check("abort_pending_wb", wr_en_a, 1);
      rst = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_wr_en_a", wr_en_a, 0);
      check("abort_wr_en_b", wr_en_b, 0);
      check("abort_wr_sel", wr_sel, 3);
      check("abort_bf_en_low", bf_en, 0);
      check("abort_stage_clr", stage, 0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("post_abort_wr", wr_en_a, 0);
      end

      // Run 3: a fresh transform after the abort.
      start = 1'b1;
      tick();
      start = 1'b0;
      do_load();
      do_compute(44);
      do_unload();
      check("done_count_2", done_cnt, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
